// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing a single-port data memory between the core and debug ports.
// Latency: gnt 1 cycle after req is sampled, read rvalid RD_LAT+2 cycles after; one transaction in flight.
// Backpressure: a requester holds req until gnt (write) or rvalid (read); c_stall covers the core meanwhile.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        win_dbg;
  logic        last_dbg;
  logic        lat_we;
  logic [2:0]  cnt;
  logic        pick_dbg;

  // Debug wins only when it is alone or the core was served last.
  assign pick_dbg = d_req & (~c_req | ~last_dbg);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (c_req | d_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? IDLE : WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      win_dbg     <= 1'b0;
      last_dbg    <= 1'b1;
      lat_we      <= 1'b0;
      cnt         <= 3'd0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      c_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (c_req | d_req) begin
            win_dbg     <= pick_dbg;
            last_dbg    <= pick_dbg;
            lat_we      <= pick_dbg ? d_we    : c_we;
            mem_addr    <= pick_dbg ? d_addr  : c_addr;
            mem_wr_data <= pick_dbg ? d_wdata : c_wdata;
          end
        end
        ISSUE: cnt <= 3'(RD_LAT);
        WAIT: begin
          cnt <= cnt - 3'd1;
          // Counter at 1 marks the cycle mem_rd_data is valid.
          if (cnt == 3'd1) begin
            if (win_dbg) d_rdata <= mem_rd_data;
            else         c_rdata <= mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wr   = (state == ISSUE) &  lat_we;
  assign mem_rd   = (state == ISSUE) & ~lat_we;
  assign c_gnt    = (state == ISSUE) & ~win_dbg;
  assign d_gnt    = (state == ISSUE) &  win_dbg;
  assign c_rvalid = (state == RESP)  & ~win_dbg;
  assign d_rvalid = (state == RESP)  &  win_dbg;
  assign c_stall  = c_req & ~((c_gnt & c_we) | c_rvalid);

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3, each with a memory model.
module tb_dmem_arbiter;

  typedef struct {
    int          dut;
    bit          port;   // 0 core, 1 debug
    bit          rv;     // 0 grant event, 1 rvalid event
    bit          we;
    logic [8:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req [2], c_we [2], d_req [2], d_we [2];
  logic [8:0]  c_addr [2], d_addr [2];
  logic [31:0] c_wdata [2], d_wdata [2];
  logic        c_gnt [2], c_rvalid [2], c_stall [2], d_gnt [2], d_rvalid [2];
  logic [31:0] c_rdata [2], d_rdata [2];
  logic        mem_wr [2], mem_rd [2];
  logic [8:0]  mem_addr [2];
  logic [31:0] mem_wr_data [2];

  logic [31:0] mem0 [0:511];
  logic [31:0] mem1 [0:511];
  logic [31:0] rd0;
  logic [31:0] pipe1 [0:2];
  logic [31:0] ref_mem [0:1][0:511];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(1)) dut0 (
    .clk(clk), .reset(reset),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_gnt(c_gnt[0]), .c_rvalid(c_rvalid[0]), .c_rdata(c_rdata[0]), .c_stall(c_stall[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_wr(mem_wr[0]), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
    .mem_wr_data(mem_wr_data[0]), .mem_rd_data(rd0)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(3)) dut1 (
    .clk(clk), .reset(reset),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_gnt(c_gnt[1]), .c_rvalid(c_rvalid[1]), .c_rdata(c_rdata[1]), .c_stall(c_stall[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_wr(mem_wr[1]), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
    .mem_wr_data(mem_wr_data[1]), .mem_rd_data(pipe1[2])
  );

  // Memory models: data appears RD_LAT cycles after the mem_rd cycle.
  always @(posedge clk) begin
    if (mem_wr[0]) mem0[mem_addr[0]] <= mem_wr_data[0];
    if (mem_rd[0]) rd0 <= mem0[mem_addr[0]];
    if (mem_wr[1]) mem1[mem_addr[1]] <= mem_wr_data[1];
    if (mem_rd[1]) pipe1[0] <= mem1[mem_addr[1]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  task automatic issue(int u, bit port, bit we, logic [8:0] a, logic [31:0] d);
    if (port) begin d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = a; d_wdata[u] = d; end
    else      begin c_req[u] = 1'b1; c_we[u] = we; c_addr[u] = a; c_wdata[u] = d; end
  endtask

  task automatic expect_gnt(int u, bit port, bit we, logic [8:0] a, logic [31:0] d, int at);
    exp_t e;
    e.dut = u; e.port = port; e.rv = 1'b0; e.we = we; e.addr = a; e.data = d; e.cyc = at;
    sb.push_back(e);
    if (we) ref_mem[u][a] = d;
  endtask

  task automatic expect_rv(int u, bit port, logic [8:0] a, int at);
    exp_t e;
    e.dut = u; e.port = port; e.rv = 1'b1; e.we = 1'b0; e.addr = a; e.data = ref_mem[u][a]; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #4;
      if (sb.size() == 0 && !(c_req[0] | d_req[0] | c_req[1] | d_req[1])) break;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin c_req[u] = 1'b0; d_req[u] = 1'b0; end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({c_gnt[u], d_gnt[u], c_rvalid[u], d_rvalid[u], mem_wr[u], mem_rd[u], c_stall[u]} !== 7'b0) begin
        errors++; $display("FAIL reset_strobes dut%0d: got %b expected 0000000", u,
          {c_gnt[u], d_gnt[u], c_rvalid[u], d_rvalid[u], mem_wr[u], mem_rd[u], c_stall[u]});
      end
      checks++;
      if ({mem_addr[u], mem_wr_data[u], c_rdata[u], d_rdata[u]} !== '0) begin
        errors++; $display("FAIL reset_regs dut%0d: addr %h wdata %h crdata %h drdata %h expected all 0",
          u, mem_addr[u], mem_wr_data[u], c_rdata[u], d_rdata[u]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_core_write();
    int k0;
    bit exp_st;
    @(negedge clk);
    issue(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF);
    k0 = cyc;
    expect_gnt(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, k0 + 1);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1; exp_st = (i == 0); checks++;
      if (c_stall[0] !== exp_st) begin
        errors++; $display("FAIL core_write_stall cycle %0d: got %b expected %b", i, c_stall[0], exp_st);
      end
    end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL core_write_done: %0d events missing, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_core_read();
    int k0;
    bit exp_st;
    @(negedge clk);
    issue(0, 1'b0, 1'b0, 9'h005, 32'h0);
    k0 = cyc;
    expect_gnt(0, 1'b0, 1'b0, 9'h005, 32'h0, k0 + 1);
    expect_rv(0, 1'b0, 9'h005, k0 + 3);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1; exp_st = (i < 3); checks++;
      if (c_stall[0] !== exp_st) begin
        errors++; $display("FAIL core_read_stall cycle %0d: got %b expected %b", i, c_stall[0], exp_st);
      end
    end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL core_read_done: %0d events missing, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_tie_writes();
    int k0;
    pulse_reset();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      issue(0, 1'b0, 1'b1, 9'(9'h040 + b), 32'hC0DE_0000 + b);
      issue(0, 1'b1, 1'b1, 9'(9'h080 + b), 32'hDB60_0000 + b);
      k0 = cyc;
      expect_gnt(0, 1'b0, 1'b1, 9'(9'h040 + b), 32'hC0DE_0000 + b, k0 + 1);
      expect_gnt(0, 1'b1, 1'b1, 9'(9'h080 + b), 32'hDB60_0000 + b, k0 + 3);
      drain();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL tie_burst%0d: %0d events missing, expected 0", b, sb.size()); sb.delete(); end
    end
  endtask

  task automatic test_rd_lat3();
    int k0;
    @(negedge clk);
    issue(1, 1'b1, 1'b1, 9'h1FF, 32'hCAFEF00D); k0 = cyc;
    expect_gnt(1, 1'b1, 1'b1, 9'h1FF, 32'hCAFEF00D, k0 + 1);
    drain();
    @(negedge clk);
    issue(1, 1'b0, 1'b1, 9'h020, 32'h12345678); k0 = cyc;
    expect_gnt(1, 1'b0, 1'b1, 9'h020, 32'h12345678, k0 + 1);
    drain();
    @(negedge clk);
    issue(1, 1'b0, 1'b0, 9'h020, 32'h0); k0 = cyc;
    expect_gnt(1, 1'b0, 1'b0, 9'h020, 32'h0, k0 + 1);
    expect_rv(1, 1'b0, 9'h020, k0 + 5);
    drain();
    @(negedge clk);
    issue(1, 1'b1, 1'b0, 9'h1FF, 32'h0); k0 = cyc;
    expect_gnt(1, 1'b1, 1'b0, 9'h1FF, 32'h0, k0 + 1);
    expect_rv(1, 1'b1, 9'h1FF, k0 + 5);
    for (int i = 0; i < 7; i++) begin
      if (i != 0) @(negedge clk);
      #1; checks++;
      if ({c_gnt[1], c_rvalid[1], c_stall[1]} !== 3'b000 || c_rdata[1] !== 32'h12345678) begin
        errors++; $display("FAIL lat3_core_quiet cycle %0d: strobes %b rdata %h expected 000 12345678",
          i, {c_gnt[1], c_rvalid[1], c_stall[1]}, c_rdata[1]);
      end
    end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL lat3_done: %0d events missing, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    int k0;
    @(negedge clk);
    issue(0, 1'b0, 1'b0, 9'h005, 32'h0); k0 = cyc;
    expect_gnt(0, 1'b0, 1'b0, 9'h005, 32'h0, k0 + 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    c_req[0] = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({c_gnt[0], d_gnt[0], c_rvalid[0], d_rvalid[0], mem_wr[0], mem_rd[0], c_stall[0]} !== 7'b0 ||
        {mem_addr[0], mem_wr_data[0], c_rdata[0], d_rdata[0]} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: strobes %b addr %h wdata %h crdata %h expected all 0",
        {c_gnt[0], d_gnt[0], c_rvalid[0], d_rvalid[0], mem_wr[0], mem_rd[0], c_stall[0]},
        mem_addr[0], mem_wr_data[0], c_rdata[0]);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL reset_mid_grant: %0d events missing, expected 0", sb.size()); sb.delete(); end
    @(negedge clk);
    issue(0, 1'b0, 1'b1, 9'h008, 32'h0BADF00D); k0 = cyc;
    expect_gnt(0, 1'b0, 1'b1, 9'h008, 32'h0BADF00D, k0 + 1);
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL reset_mid_recover: %0d events missing, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_core_held();
    int k0;
    bit exp_st;
    @(negedge clk);
    issue(0, 1'b0, 1'b1, 9'h009, 32'h99990000); k0 = cyc;
    expect_gnt(0, 1'b0, 1'b1, 9'h009, 32'h99990000, k0 + 1);
    drain();
    @(negedge clk);
    issue(0, 1'b0, 1'b0, 9'h005, 32'h0);
    issue(0, 1'b1, 1'b1, 9'h030, 32'h0000A5A5);
    k0 = cyc;
    expect_gnt(0, 1'b1, 1'b1, 9'h030, 32'h0000A5A5, k0 + 1);
    expect_gnt(0, 1'b0, 1'b0, 9'h005, 32'h0, k0 + 3);
    expect_rv(0, 1'b0, 9'h005, k0 + 5);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      #1; exp_st = (i < 5); checks++;
      if (c_stall[0] !== exp_st) begin
        errors++; $display("FAIL held_stall cycle %0d: got %b expected %b", i, c_stall[0], exp_st);
      end
    end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL held_done: %0d events missing, expected 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      c_req[u] = 1'b0; c_we[u] = 1'b0; c_addr[u] = '0; c_wdata[u] = '0;
      d_req[u] = 1'b0; d_we[u] = 1'b0; d_addr[u] = '0; d_wdata[u] = '0;
    end
    fork
      // Scoreboard monitor: every grant/rvalid must match the queue head.
      forever begin
        @(negedge clk); #2;
        for (int u = 0; u < 2; u++) begin
          if (!reset) begin
            checks++;
            if ((c_gnt[u] | c_rvalid[u]) && (d_gnt[u] | d_rvalid[u])) begin
              errors++; $display("FAIL both_ports dut%0d cycle %0d: core and debug strobes together", u, cyc);
            end
            checks++;
            if ((mem_wr[u] | mem_rd[u]) !== (c_gnt[u] | d_gnt[u])) begin
              errors++; $display("FAIL mem_strobe dut%0d cycle %0d: wr/rd %b%b gnt %b%b", u, cyc,
                mem_wr[u], mem_rd[u], c_gnt[u], d_gnt[u]);
            end
            if (c_gnt[u] | d_gnt[u] | c_rvalid[u] | d_rvalid[u]) begin
              checks++;
              if (sb.size() == 0 || sb[0].dut != u) begin
                errors++; $display("FAIL unexpected_event dut%0d cycle %0d: gnt %b%b rvalid %b%b", u, cyc,
                  c_gnt[u], d_gnt[u], c_rvalid[u], d_rvalid[u]);
              end else begin
                e = sb.pop_front();
                if ({d_gnt[u] | d_rvalid[u], c_rvalid[u] | d_rvalid[u]} !== {e.port, e.rv} || cyc != e.cyc) begin
                  errors++; $display("FAIL event_order dut%0d: got port %b rv %b cycle %0d expected port %b rv %b cycle %0d",
                    u, d_gnt[u] | d_rvalid[u], c_rvalid[u] | d_rvalid[u], cyc, e.port, e.rv, e.cyc);
                end
                checks++;
                if (!e.rv) begin
                  if (mem_addr[u] !== e.addr || mem_wr[u] !== e.we || (e.we && mem_wr_data[u] !== e.data)) begin
                    errors++; $display("FAIL mem_issue dut%0d: got addr %h wr %b data %h expected addr %h wr %b data %h",
                      u, mem_addr[u], mem_wr[u], mem_wr_data[u], e.addr, e.we, e.data);
                  end
                end else if ((e.port ? d_rdata[u] : c_rdata[u]) !== e.data) begin
                  errors++; $display("FAIL rdata dut%0d port %0d: got %h expected %h",
                    u, e.port, e.port ? d_rdata[u] : c_rdata[u], e.data);
                end
              end
            end
          end
        end
      end
      // Requester model: drop req in the cycle after completion.
      forever begin
        @(negedge clk); #3;
        for (int u = 0; u < 2; u++) begin
          if ((c_gnt[u] && c_we[u]) || c_rvalid[u]) c_req[u] = 1'b0;
          if ((d_gnt[u] && d_we[u]) || d_rvalid[u]) d_req[u] = 1'b0;
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(negedge clk);
    test_reset();
    test_core_write();
    test_core_read();
    test_tie_writes();
    test_rd_lat3();
    test_reset_mid();
    test_core_held();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_queue: %0d events pending, expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
